// File: rtl/window_3x3_gen.sv
// window_3x3_gen: streams 1-bit raster pixels through two line buffers and
// emits every fully-inside 3x3 neighbourhood as a 9-bit word with a strobe.
module window_3x3_gen #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pix_in,
   input  logic       pix_valid,
   input  logic       sof,
   output logic [8:0] X,
   output logic       win_valid,
   output logic       frame_done,
   output logic       frame_err
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t state, state_nx;
   logic [CW-1:0] col, col_nx, cur_c;
   logic [RW-1:0] row, row_nx, cur_r;
   logic [IMG_W-1:0] lb1, lb2;
   logic [2:0] w_top, w_mid, w_bot;
   logic accept, restart, eol, last_px, emit;
   // a qualified sof always places the current pixel at (0,0)
   always_comb begin
      restart = pix_valid & sof;
      accept = pix_valid & (sof | state == ACTIVE);
      cur_c = restart ? '0 : col;
      cur_r = restart ? '0 : row;
      eol = cur_c == CW'(IMG_W - 1);
      last_px = eol & (cur_r == RW'(IMG_H - 1));
      emit = accept & (cur_r >= RW'(2)) & (cur_c >= CW'(2));
      col_nx = col;
      row_nx = row;
      state_nx = state;
      if (accept) begin
         col_nx = eol ? '0 : cur_c + CW'(1);
         row_nx = last_px ? '0 : eol ? cur_r + RW'(1) : cur_r;
         state_nx = last_px ? IDLE : ACTIVE;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         col <= '0;
         row <= '0;
         lb1 <= '0;
         lb2 <= '0;
         w_top <= '0;
         w_mid <= '0;
         w_bot <= '0;
         X <= '0;
         win_valid <= 1'b0;
         frame_done <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state <= state_nx;
         col <= col_nx;
         row <= row_nx;
         win_valid <= emit;
         frame_done <= accept & last_px;
         frame_err <= restart & (state == ACTIVE);
         if (accept) begin
            lb2[cur_c] <= lb1[cur_c];
            lb1[cur_c] <= pix_in;
            w_top <= {w_top[1:0], lb2[cur_c]};
            w_mid <= {w_mid[1:0], lb1[cur_c]};
            w_bot <= {w_bot[1:0], pix_in};
            if (emit) X <= {w_top[1:0], lb2[cur_c], w_mid[1:0], lb1[cur_c], w_bot[1:0], pix_in};
         end
      end
   end
endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: directed checks of the 3x3 window generator on 4x4 frames.
module tb_window_3x3_gen;
   logic clk = 1'b0, rst_n = 1'b0, pix_in = 1'b0, pix_valid = 1'b0, sof = 1'b0;
   logic [8:0] X;
   logic win_valid, frame_done, frame_err;
   logic [8:0] last_x = 9'h000;
   logic [8:0] cb [4] = '{9'h0AA, 9'h155, 9'h155, 9'h0AA};
   int checks = 0, errors = 0;

   window_3x3_gen #(.IMG_W(4), .IMG_H(4)) dut (
      .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
      .X(X), .win_valid(win_valid), .frame_done(frame_done), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic outs(input logic ev, input logic ed, input logic ee);
      chk("win_valid", 9'(win_valid), 9'(ev));
      chk("X", X, last_x);
      chk("frame_done", 9'(frame_done), 9'(ed));
      chk("frame_err", 9'(frame_err), 9'(ee));
   endtask

   task automatic px(input logic p, input logic s, input logic ev, input logic [8:0] ex,
                     input logic ed, input logic ee);
      @(negedge clk);
      pix_in = p;
      sof = s;
      pix_valid = 1'b1;
      @(posedge clk);
      #1;
      if (ev) last_x = ex;
      outs(ev, ed, ee);
   endtask

   task automatic gap();
      @(negedge clk);
      pix_valid = 1'b0;
      sof = 1'b0;
      @(posedge clk);
      #1;
      outs(1'b0, 1'b0, 1'b0);
   endtask

   // pixels start..15 of a 4x4 frame; ones=0 gives checkerboard (r+c)%2
   task automatic frame(input logic ones, input int start, input int gaps);
      int k, r, c;
      logic p, w;
      k = 0;
      for (int i = start; i < 16; i++) begin
         r = i / 4;
         c = i % 4;
         p = ones ? 1'b1 : 1'((r + c) % 2);
         w = (r >= 2) && (c >= 2);
         px(p, i == 0, w, ones ? 9'h1FF : cb[k], i == 15, 1'b0);
         if (w) k++;
         for (int g = 0; g < gaps; g++) gap();
      end
      gap();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      outs(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      frame(1'b1, 0, 0);
      frame(1'b0, 0, 0);
      frame(1'b0, 0, 3);
      for (int i = 0; i < 5; i++) px(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
      gap();
      frame(1'b0, 0, 0);
      // restart at (2,1): old frame yields no windows, error pulse follows sof
      for (int i = 0; i < 9; i++) px(1'((i / 4 + i % 4) % 2), i == 0, 1'b0, 9'h000, 1'b0, 1'b0);
      px(1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b1);
      frame(1'b0, 1, 0);
      for (int i = 0; i < 13; i++) begin
         px(1'((i / 4 + i % 4) % 2), i == 0, i == 10 || i == 11,
            (i == 10) ? 9'h0AA : 9'h155, 1'b0, 1'b0);
      end
      @(negedge clk);
      pix_valid = 1'b0;
      sof = 1'b0;
      rst_n = 1'b0;
      #1;
      last_x = 9'h000;
      outs(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      px(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
      gap();
      frame(1'b0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
